// File: rtl/rom_loader_pkg.sv
// Shared constants for the SPI ROM loader: command codes and FSM state encodings.
package rom_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CMD  = 3'd1;
  localparam state_t ST_ADR2 = 3'd2;
  localparam state_t ST_ADR1 = 3'd3;
  localparam state_t ST_ADR0 = 3'd4;
  localparam state_t ST_DATA = 3'd5;
  localparam state_t ST_SKIP = 3'd6;

endpackage

// File: rtl/rom_loader_spi_rx_sync.sv
// SPI mode-0 receiver in the system clock domain: synchronisers, spi_ck rise
// detect, bit counter and shift register. byte_rdy is a one-cycle pulse.
module spi_rx_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_ss,
  input  logic       spi_ck,
  input  logic       spi_mosi,
  output logic       ss_n,
  output logic       ss_rise,
  output logic       ss_fall,
  output logic       byte_rdy,
  output logic [7:0] rx_byte
);

  logic [1:0] ss_sync_q, ck_sync_q, mosi_sync_q;
  logic       ss_prev_q, ck_prev_q;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ck_rise;

  // ss synchroniser resets low so a select already held low after reset
  // shows no falling edge and cannot start a transaction mid-stream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ss_sync_q   <= 2'b00;
      ck_sync_q   <= 2'b00;
      mosi_sync_q <= 2'b00;
      ss_prev_q   <= 1'b0;
      ck_prev_q   <= 1'b0;
      cnt_q       <= 3'd0;
      shift_q     <= 8'h00;
    end else begin
      ss_sync_q   <= {ss_sync_q[0], spi_ss};
      ck_sync_q   <= {ck_sync_q[0], spi_ck};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      ss_prev_q   <= ss_sync_q[1];
      ck_prev_q   <= ck_sync_q[1];
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
    end
  end

  assign ss_n    = ss_sync_q[1];
  assign ss_rise = ss_n & ~ss_prev_q;
  assign ss_fall = ~ss_n & ss_prev_q;
  assign ck_rise = ck_sync_q[1] & ~ck_prev_q;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (ss_n) begin
      cnt_d = 3'd0;
    end else if (ck_rise) begin
      cnt_d   = cnt_q + 3'd1;
      shift_d = {shift_q[6:0], mosi_sync_q[1]};
    end
  end

  // mosi went through the same flop depth as spi_ck, so it lines up with ck_rise.
  assign byte_rdy = ck_rise & ~ss_n & (cnt_q == 3'd7);
  assign rx_byte  = {shift_q[6:0], mosi_sync_q[1]};

endmodule

// File: rtl/rom_loader.sv
// Boot-time SPI loader: command + 24-bit address, then one memory write per
// data byte with address auto-increment. busy holds the CPU in reset.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter  int KB = 64,
  localparam int AW = $clog2(KB*1024)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          spi_ss,
  input  logic          spi_ck,
  input  logic          spi_mosi,
  output logic [AW-1:0] a,
  output logic [7:0]    d,
  output logic          w,
  output logic          busy
);

  logic       ss_n, ss_rise, ss_fall, byte_rdy;
  logic [7:0] rx_byte;

  spi_rx_sync u_rx (
    .clock    (clock),
    .reset    (reset),
    .spi_ss   (spi_ss),
    .spi_ck   (spi_ck),
    .spi_mosi (spi_mosi),
    .ss_n     (ss_n),
    .ss_rise  (ss_rise),
    .ss_fall  (ss_fall),
    .byte_rdy (byte_rdy),
    .rx_byte  (rx_byte)
  );

  state_t        state_q, state_d;
  logic [AW-1:0] a_q, a_d;
  logic [7:0]    d_q, d_d;
  logic          w_q, w_d;
  logic          busy_q, busy_d;
  logic [15:0]   adr_hi_q, adr_hi_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ss_n) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (ss_fall)  state_d = ST_CMD;
        ST_CMD:  if (byte_rdy) state_d = (rx_byte == CMD_WRITE) ? ST_ADR2 : ST_SKIP;
        ST_ADR2: if (byte_rdy) state_d = ST_ADR1;
        ST_ADR1: if (byte_rdy) state_d = ST_ADR0;
        ST_ADR0: if (byte_rdy) state_d = ST_DATA;
        ST_DATA: state_d = ST_DATA;
        ST_SKIP: state_d = ST_SKIP;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // byte_rdy is already gated by a low select, so ss always wins over a late byte.
  always_comb begin
    a_d      = a_q;
    d_d      = d_q;
    w_d      = 1'b0;
    busy_d   = busy_q;
    adr_hi_d = adr_hi_q;
    if (w_q) a_d = a_q + AW'(1);
    if (ss_rise) busy_d = 1'b0;
    if (byte_rdy) begin
      case (state_q)
        ST_CMD:  if (rx_byte == CMD_WRITE) busy_d = 1'b1;
        ST_ADR2: adr_hi_d[15:8] = rx_byte;
        ST_ADR1: adr_hi_d[7:0]  = rx_byte;
        ST_ADR0: a_d = AW'({adr_hi_q, rx_byte});
        ST_DATA: begin
          d_d = rx_byte;
          w_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      d_q      <= 8'h00;
      w_q      <= 1'b0;
      busy_q   <= 1'b0;
      adr_hi_q <= 16'h0000;
    end else begin
      a_q      <= a_d;
      d_q      <= d_d;
      w_q      <= w_d;
      busy_q   <= busy_d;
      adr_hi_q <= adr_hi_d;
    end
  end

  assign a    = a_q;
  assign d    = d_q;
  assign w    = w_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: a 64 KiB and a 16 KiB instance share the SPI pins;
// expected writes are queued at stimulus time and matched against observed w pulses.
`timescale 1ns/1ps
module tb_rom_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        spi_ss = 1'b1, spi_ck = 1'b0, spi_mosi = 1'b0;
  logic [15:0] a64;
  logic [13:0] a16;
  logic [7:0]  d64, d16;
  logic        w64, w16, busy64, busy16;

  always #5 clock = ~clock;

  rom_loader #(.KB(64)) dut64 (
    .clock(clock), .reset(reset), .spi_ss(spi_ss), .spi_ck(spi_ck), .spi_mosi(spi_mosi),
    .a(a64), .d(d64), .w(w64), .busy(busy64)
  );
  rom_loader #(.KB(16)) dut16 (
    .clock(clock), .reset(reset), .spi_ss(spi_ss), .spi_ck(spi_ck), .spi_mosi(spi_mosi),
    .a(a16), .d(d16), .w(w16), .busy(busy16)
  );

  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  typedef struct {
    string            name;
    int               nb;
    logic [0:7][7:0]  b;
    int               nw;
    logic [23:0]      a0;
    bit               busy;
  } vec_t;

  wr_t  expq[$];
  wr_t  obs64[$], obs16[$];
  int   bcnt64 = 0;
  int   nchk = 0, nerr = 0;
  vec_t vecs[$];

  // Every w-high cycle is logged, so a stretched pulse shows up as an extra write.
  always @(negedge clock) begin
    if (w64) obs64.push_back('{a: 32'(a64), d: d64});
    if (w16) obs16.push_back('{a: 32'(a16), d: d16});
    if (busy64) bcnt64++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_wr(input logic [23:0] adr, input logic [7:0] dat);
    expq.push_back('{a: 32'(adr), d: dat});
  endtask

  task automatic drain(input string nm);
    check({nm, "_nwr64"}, obs64.size(), expq.size());
    check({nm, "_nwr16"}, obs16.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < obs64.size()) begin
        check({nm, "_a64"}, obs64[i].a, expq[i].a & 32'hFFFF);
        check({nm, "_d64"}, obs64[i].d, expq[i].d);
      end
      if (i < obs16.size()) begin
        check({nm, "_a16"}, obs16[i].a, expq[i].a & 32'h3FFF);
        check({nm, "_d16"}, obs16[i].d, expq[i].d);
      end
    end
    expq.delete();
    obs64.delete();
    obs16.delete();
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      #20 spi_ck = 1'b1;
      #20 spi_ck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8);
  endtask

  // Random phase of the SPI edges against the system clock, spi_ck = clock/4.
  task automatic ss_start();
    @(posedge clock);
    #($urandom_range(1, 9));
    spi_ss = 1'b0;
    #40;
  endtask

  task automatic ss_end();
    #40 spi_ss = 1'b1;
    repeat (8) @(posedge clock);
    #1;
  endtask

  task automatic add_vec(input string nm, input int nb, input logic [63:0] b,
                         input int nw, input logic [23:0] a0, input bit bz);
    vec_t v;
    v.name = nm; v.nb = nb; v.b = b; v.nw = nw; v.a0 = a0; v.busy = bz;
    vecs.push_back(v);
  endtask

  initial begin
    int b0;
    logic [23:0] adr;
    logic [7:0]  dat;

    add_vec("single",   6, 64'h01_00_00_10_AB_CD_00_00, 2, 24'h000010, 1'b1);
    add_vec("wrap",     6, 64'h01_00_FF_FF_11_22_00_00, 2, 24'h00FFFF, 1'b1);
    add_vec("wrap16",   6, 64'h01_01_3F_FF_11_22_00_00, 2, 24'h013FFF, 1'b1);
    add_vec("badcmd",   5, 64'h7E_00_00_00_55_00_00_00, 0, 24'h000000, 1'b0);
    add_vec("hibits",   5, 64'h01_12_34_56_77_00_00_00, 1, 24'h123456, 1'b1);
    add_vec("adrabort", 3, 64'h01_00_00_00_00_00_00_00, 0, 24'h000000, 1'b1);
    add_vec("cmdonly",  1, 64'h01_00_00_00_00_00_00_00, 0, 24'h000000, 1'b1);

    #1;
    check("rst_a",    32'(a64), 0);
    check("rst_d",    32'(d64), 0);
    check("rst_w",    32'(w64), 0);
    check("rst_busy", 32'(busy64), 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (4) @(posedge clock);

    foreach (vecs[vi]) begin
      b0 = bcnt64;
      ss_start();
      for (int k = 0; k < vecs[vi].nb; k++) spi_byte(vecs[vi].b[k]);
      for (int k = 0; k < vecs[vi].nw; k++) push_wr(vecs[vi].a0 + 24'(k), vecs[vi].b[4 + k]);
      repeat (6) @(posedge clock);
      #1;
      check({vecs[vi].name, "_busy64"}, 32'(busy64), 32'(vecs[vi].busy));
      check({vecs[vi].name, "_busy16"}, 32'(busy16), 32'(vecs[vi].busy));
      ss_end();
      check({vecs[vi].name, "_busy_off"}, 32'(busy64), 0);
      check({vecs[vi].name, "_busy_seen"}, 32'(bcnt64 != b0), 32'(vecs[vi].busy));
      drain(vecs[vi].name);
    end

    // Select released mid-byte: the partial byte must not be written.
    ss_start();
    spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h5A);
    push_wr(24'h000000, 8'h5A);
    spi_bits(8'hF0, 4);
    ss_end();
    drain("abort_mid");
    ss_start();
    spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h40); spi_byte(8'hC3);
    push_wr(24'h000040, 8'hC3);
    ss_end();
    drain("after_abort");

    // Reset between data bytes drops w/busy/a asynchronously.
    ss_start();
    spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h20); spi_byte(8'hAA);
    push_wr(24'h000020, 8'hAA);
    repeat (8) @(posedge clock);
    #1;
    check("pre_rst_busy", 32'(busy64), 1);
    check("pre_rst_a",    32'(a64), 32'h21);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_w",      32'(w64), 0);
    check("rst_mid_busy64", 32'(busy64), 0);
    check("rst_mid_busy16", 32'(busy16), 0);
    check("rst_mid_a64",    32'(a64), 0);
    check("rst_mid_a16",    32'(a16), 0);
    spi_ss = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (4) @(posedge clock);
    drain("pre_rst");
    ss_start();
    spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h05); spi_byte(8'hEE);
    push_wr(24'h000005, 8'hEE);
    ss_end();
    drain("post_rst");

    // 256 random data bytes over four transactions, each with its own phase.
    for (int t = 0; t < 4; t++) begin
      adr = 24'($urandom);
      ss_start();
      spi_byte(8'h01); spi_byte(adr[23:16]); spi_byte(adr[15:8]); spi_byte(adr[7:0]);
      for (int k = 0; k < 64; k++) begin
        dat = 8'($urandom);
        push_wr(adr + 24'(k), dat);
        spi_byte(dat);
      end
      ss_end();
      drain("random");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
